acq_sequencer: RTL and testbench
================================

// Module: acq_sequencer
// PURPOSE
//  Control-plane sequencer for the ADC capture path. Latches the capture config, waits for a
//  software or external trigger and issues N back-to-back packet requests (start/dsize/test).
//  Tracks completion via the receiver's sr_pc flag, spaces frames by a programmable gap,
//  guards each frame with a watchdog and reports sticky status plus an irq pulse to the register file.
// PARAMETERS
//  CNT_W        32  width of dsize, frame count, interval and timeout fields
//  SYNC_STAGES  2   flip-flop stages on the asynchronous ext_trig input (>=2)
// PORTS
//  s00_axi_aclk     in   1      single clock for the whole block
//  s00_axi_aresetn  in   1      asynchronous, active-low reset
//  ctrl_arm         in   1      1-cycle pulse: latch cfg_*, begin sequence (ignored unless IDLE)
//  ctrl_abort       in   1      1-cycle pulse: return to IDLE from any state
//  cfg_dsize        in   CNT_W  words per packet
//  cfg_test         in   1      receiver test mode
//  cfg_frames       in   CNT_W  packets per sequence; 0 = continuous until abort
//  cfg_interval     in   CNT_W  idle cycles between packet completion and next start
//  cfg_timeout      in   CNT_W  watchdog limit in cycles per packet; 0 = disabled
//  cfg_trig_src     in   1      0 = sw_trig, 1 = ext_trig
//  sw_trig          in   1      1-cycle software trigger pulse
//  ext_trig         in   1      asynchronous external trigger, rising-edge active
//  rx_start         out  1      start request to receiver
//  rx_dsize         out  CNT_W  latched packet size to receiver
//  rx_test          out  1      latched test mode to receiver
//  rx_sr_pc         in   1      receiver idle/packet-complete flag (1 = idle)
//  sts_busy         out  1      1 in any state except IDLE
//  sts_done         out  1      sticky: cfg_frames packets completed
//  sts_timeout      out  1      sticky: watchdog expired
//  sts_frame_cnt    out  CNT_W  packets completed in current sequence
//  irq              out  1      1-cycle pulse on entry to DONE or on timeout
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; shadow registers, counters and sync flops 0.
//  IDLE: ctrl_arm -> latch cfg_* into shadows, clear sts_done/sts_timeout/sts_frame_cnt -> WAIT_TRIG.
//  WAIT_TRIG: trigger accepted only when rx_sr_pc=1; accepted -> START. Trigger while rx_sr_pc=0 dropped.
//  START: rx_start=1 held until rx_sr_pc=0 -> RUN (rx_start drops the same cycle the state leaves).
//  RUN: rx_start=0; rx_sr_pc=1 -> sts_frame_cnt+1; if frames!=0 and new count==frames -> DONE,
//   else interval==0 -> START, else -> GAP.
//  GAP: down-counter loaded with interval; START on the cycle it reaches 1 (gap = interval cycles).
//  DONE: sts_done=1, irq=1 for one cycle -> IDLE next cycle.
//  Watchdog: cleared on entry to START; counts in START and RUN; count==timeout (timeout!=0)
//   -> sts_timeout=1, irq pulse, rx_start=0 -> IDLE. Receiver is not reset; it finishes its packet.
//  Abort: highest priority; any state -> IDLE next cycle, rx_start=0, no irq, sticky flags kept.
//  Simultaneous: abort+arm -> abort wins; abort+timeout -> abort, sts_timeout not set;
//   RUN completion and timeout same cycle -> completion wins.
//  Continuous mode: sts_frame_cnt wraps 2^CNT_W-1 -> 0, sequence continues.
//  rx_dsize/rx_test change only on arm; cfg_* changes mid-sequence have no effect.
//  Latency: trigger -> rx_start = 1 cycle (sw) / SYNC_STAGES+2 cycles (ext).
// CONFIGURATION
//  ACQ_SEQ_EXT_TRIG_EN defined: SYNC_STAGES synchronizer + rising-edge detector on ext_trig;
//   cfg_trig_src selects source.
//  Not defined: no sync logic; ext_trig ignored, cfg_trig_src treated as 0. Port list unchanged.
// TESTING
//  1 frames=3,interval=0,dsize=16, sw_trig; BFM drops sr_pc 2 cyc after start, raises 20 cyc later
//    -> 3 start handshakes, frame_cnt 1,2,3, sts_done=1, one irq pulse, busy=0.
//  2 frames=2,interval=10 -> next rx_start rises exactly 10 cyc after sr_pc returns high.
//  3 timeout=50, BFM never drops sr_pc -> rx_start falls, sts_timeout=1, irq 50 cyc after START entry.
//  4 frames=0, abort after 5 packets -> IDLE next cycle, frame_cnt=5, no irq, sts_done=0.
//  5 trig_src=1, ext_trig edge async to clk (macro on) -> rx_start after SYNC_STAGES+2 cyc;
//    macro off -> no start.
//  6 Reset asserted in RUN -> all outputs 0 immediately; arm+abort same cycle -> stays IDLE.

Source files
------------

// File: rtl/acq_sequencer.sv
// ADC capture sequencer: arm -> trigger -> N receiver packet requests with inter-frame gap and watchdog.
// Optional feature macro ACQ_SEQ_EXT_TRIG_EN adds the synchronized, edge-detected ext_trig source.
`timescale 1ns/1ps
module acq_sequencer #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             s00_axi_aclk,
  input  logic             s00_axi_aresetn,
  input  logic             ctrl_arm,
  input  logic             ctrl_abort,
  input  logic [CNT_W-1:0] cfg_dsize,
  input  logic             cfg_test,
  input  logic [CNT_W-1:0] cfg_frames,
  input  logic [CNT_W-1:0] cfg_interval,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic             cfg_trig_src,
  input  logic             sw_trig,
  input  logic             ext_trig,
  output logic             rx_start,
  output logic [CNT_W-1:0] rx_dsize,
  output logic             rx_test,
  input  logic             rx_sr_pc,
  output logic             sts_busy,
  output logic             sts_done,
  output logic             sts_timeout,
  output logic [CNT_W-1:0] sts_frame_cnt,
  output logic             irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TRIG, S_START, S_RUN, S_GAP, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dsize_q, dsize_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             test_q, test_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             irq_q, irq_d;
  logic             arm_acc;
  logic             wd_exp;
  logic             trig;

  assign arm_acc = (state_q == S_IDLE) && ctrl_arm && !ctrl_abort;

`ifdef ACQ_SEQ_EXT_TRIG_EN
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_prev_q;
  logic                   ext_pulse_q;
  logic                   src_q;

  // Registered edge pulse gives trigger -> rx_start of SYNC_STAGES+2 cycles.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      sync_q      <= '0;
      edge_prev_q <= 1'b0;
      ext_pulse_q <= 1'b0;
      src_q       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ext_trig};
      edge_prev_q <= sync_q[SYNC_STAGES-1];
      ext_pulse_q <= sync_q[SYNC_STAGES-1] & ~edge_prev_q;
      if (arm_acc) src_q <= cfg_trig_src;
    end
  end

  assign trig = src_q ? ext_pulse_q : sw_trig;
`else
  logic unused_ext;
  assign unused_ext = ext_trig ^ cfg_trig_src;
  assign trig       = sw_trig;
`endif

  always_comb begin
    state_d    = state_q;
    dsize_d    = dsize_q;
    frames_d   = frames_q;
    interval_d = interval_q;
    timeout_d  = timeout_q;
    test_d     = test_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    wd_d       = wd_q;
    done_d     = done_q;
    tmo_d      = tmo_q;
    irq_d      = 1'b0;
    wd_exp     = (timeout_q != '0) && (wd_q == timeout_q);

    // wd_q holds the number of cycles spent since entering START, including the current one.
    if (state_q == S_START || state_q == S_RUN) wd_d = wd_q + ONE;

    if (ctrl_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_acc) begin
            dsize_d    = cfg_dsize;
            frames_d   = cfg_frames;
            interval_d = cfg_interval;
            timeout_d  = cfg_timeout;
            test_d     = cfg_test;
            cnt_d      = '0;
            done_d     = 1'b0;
            tmo_d      = 1'b0;
            state_d    = S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (trig && rx_sr_pc) begin
            state_d = S_START;
            wd_d    = ONE;
          end
        end
        S_START: begin
          if (wd_exp) begin
            tmo_d   = 1'b1;
            irq_d   = 1'b1;
            state_d = S_IDLE;
          end else if (!rx_sr_pc) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // Completion takes precedence over a watchdog expiring in the same cycle.
          if (rx_sr_pc) begin
            cnt_d = cnt_q + ONE;
            if ((frames_q != '0) && (cnt_d == frames_q)) begin
              done_d  = 1'b1;
              irq_d   = 1'b1;
              state_d = S_DONE;
            end else if (interval_q == '0) begin
              state_d = S_START;
              wd_d    = ONE;
            end else begin
              gap_d   = interval_q;
              state_d = S_GAP;
            end
          end else if (wd_exp) begin
            tmo_d   = 1'b1;
            irq_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_q == ONE) begin
            state_d = S_START;
            wd_d    = ONE;
          end else begin
            gap_d = gap_q - ONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q    <= S_IDLE;
      dsize_q    <= '0;
      frames_q   <= '0;
      interval_q <= '0;
      timeout_q  <= '0;
      test_q     <= 1'b0;
      cnt_q      <= '0;
      gap_q      <= '0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dsize_q    <= dsize_d;
      frames_q   <= frames_d;
      interval_q <= interval_d;
      timeout_q  <= timeout_d;
      test_q     <= test_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      irq_q      <= irq_d;
    end
  end

  assign rx_start      = (state_q == S_START);
  assign rx_dsize      = dsize_q;
  assign rx_test       = test_q;
  assign sts_busy      = (state_q != S_IDLE);
  assign sts_done      = done_q;
  assign sts_timeout   = tmo_q;
  assign sts_frame_cnt = cnt_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: event-level reference model checked every cycle, directed scenarios, random sequences.
`timescale 1ns/1ps
module tb_acq_sequencer;

  localparam int SYNC = 2;
  localparam longint WRAP = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_arm, ctrl_abort, cfg_test, cfg_trig_src, sw_trig, ext_trig;
  logic [31:0] cfg_dsize, cfg_frames, cfg_interval, cfg_timeout;
  logic        rx_start, rx_test, rx_sr_pc, sts_busy, sts_done, sts_timeout, irq;
  logic [31:0] rx_dsize, sts_frame_cnt;

  always #5 clk = ~clk;

  acq_sequencer #(.CNT_W(32), .SYNC_STAGES(SYNC)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .ctrl_arm(ctrl_arm), .ctrl_abort(ctrl_abort),
    .cfg_dsize(cfg_dsize), .cfg_test(cfg_test), .cfg_frames(cfg_frames),
    .cfg_interval(cfg_interval), .cfg_timeout(cfg_timeout), .cfg_trig_src(cfg_trig_src),
    .sw_trig(sw_trig), .ext_trig(ext_trig),
    .rx_start(rx_start), .rx_dsize(rx_dsize), .rx_test(rx_test), .rx_sr_pc(rx_sr_pc),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_timeout(sts_timeout),
    .sts_frame_cnt(sts_frame_cnt), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- receiver BFM ----------------
  int bfm_mode = 0;  // 0 = normal packet, 1 = never acknowledges
  int bfm_drop = 2;
  int bfm_busy = 20;
  int bfm_st   = 0;
  int bfm_cnt  = 0;

  initial begin
    rx_sr_pc = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bfm_st = 0; rx_sr_pc = 1'b1;
      end else begin
        case (bfm_st)
          0: if (rx_start && bfm_mode == 0) begin bfm_st = 1; bfm_cnt = bfm_drop; end
          1: if (bfm_cnt <= 1) begin rx_sr_pc = 1'b0; bfm_st = 2; bfm_cnt = bfm_busy; end
             else bfm_cnt--;
          default: if (bfm_cnt <= 1) begin rx_sr_pc = 1'b1; bfm_st = 0; end
                   else bfm_cnt--;
        endcase
      end
    end
  end

  // ---------------- reference model ----------------
  // Phases follow the sequencer's documented behaviour; timing is tracked as absolute
  // cycle numbers (packet start cycle, gap end cycle) rather than counters.
  localparam int P_IDLE = 0, P_WAIT = 1, P_REQ = 2, P_XFER = 3, P_GAP = 4, P_DONE = 5;
  int          m_ph;
  longint      cyc = 0;
  longint      m_t0, m_gap_end, m_frames, m_interval, m_timeout, m_cnt;
  logic [31:0] m_dsize;
  logic        m_test, m_src, m_done, m_tmo, m_irq;
  logic        hist [0:SYNC+2];

  task automatic model_reset();
    m_ph = P_IDLE; m_t0 = 0; m_gap_end = 0; m_frames = 0; m_interval = 0; m_timeout = 0;
    m_cnt = 0; m_dsize = '0; m_test = 0; m_src = 0; m_done = 0; m_tmo = 0; m_irq = 0;
    for (int j = 0; j <= SYNC+2; j++) hist[j] = 1'b0;
  endtask

  task automatic model_step();
    logic ev, trig, wd_fire;
    m_irq = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int j = SYNC+2; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = ext_trig;
    ev = hist[SYNC+1] & ~hist[SYNC+2];
`ifdef ACQ_SEQ_EXT_TRIG_EN
    trig = m_src ? ev : sw_trig;
`else
    trig = sw_trig;
`endif
    wd_fire = (m_timeout != 0) && ((cyc - m_t0) == m_timeout);
    if (ctrl_abort) m_ph = P_IDLE;
    else case (m_ph)
      P_IDLE: if (ctrl_arm) begin
        m_dsize = cfg_dsize; m_test = cfg_test; m_src = cfg_trig_src;
        m_frames = cfg_frames; m_interval = cfg_interval; m_timeout = cfg_timeout;
        m_cnt = 0; m_done = 0; m_tmo = 0; m_ph = P_WAIT;
      end
      P_WAIT: if (trig && rx_sr_pc) begin m_ph = P_REQ; m_t0 = cyc; end
      P_REQ: begin
        if (wd_fire) begin m_tmo = 1; m_irq = 1; m_ph = P_IDLE; end
        else if (!rx_sr_pc) m_ph = P_XFER;
      end
      P_XFER: begin
        if (rx_sr_pc) begin
          m_cnt = (m_cnt + 1) % WRAP;
          if (m_frames != 0 && m_cnt == m_frames) begin m_done = 1; m_irq = 1; m_ph = P_DONE; end
          else if (m_interval == 0) begin m_ph = P_REQ; m_t0 = cyc; end
          else begin m_ph = P_GAP; m_gap_end = cyc + m_interval; end
        end else if (wd_fire) begin m_tmo = 1; m_irq = 1; m_ph = P_IDLE; end
      end
      P_GAP: if (cyc == m_gap_end) begin m_ph = P_REQ; m_t0 = cyc; end
      default: m_ph = P_IDLE;
    endcase
  endtask

  // ---------------- compare process + event monitor ----------------
  int     n_starts = 0, n_irq = 0;
  longint srpc_rise = 0, start_rise = 0, start_gap = 0, irq_cyc = 0;
  logic   srpc_prev = 1'b1, start_prev = 1'b0;

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rx_sr_pc && !srpc_prev) srpc_rise = cyc;
      srpc_prev = rx_sr_pc;
      model_step();
      #1;
      if (rx_start && !start_prev) begin
        n_starts++; start_rise = cyc; start_gap = cyc - srpc_rise;
      end
      start_prev = rx_start;
      if (irq) begin n_irq++; irq_cyc = cyc; end
      chk("m_rx_start", rx_start, m_ph == P_REQ);
      chk("m_busy", sts_busy, m_ph != P_IDLE);
      chk("m_dsize", rx_dsize, m_dsize);
      chk("m_test", rx_test, m_test);
      chk("m_done", sts_done, m_done);
      chk("m_timeout", sts_timeout, m_tmo);
      chk("m_frame_cnt", sts_frame_cnt, m_cnt[31:0]);
      chk("m_irq", irq, m_irq);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cfg(input logic [31:0] fr, input logic [31:0] iv, input logic [31:0] to,
                         input logic [31:0] ds, input logic tst, input logic src);
    cfg_frames = fr; cfg_interval = iv; cfg_timeout = to; cfg_dsize = ds;
    cfg_test = tst; cfg_trig_src = src;
  endtask

  task automatic pulse_arm();   @(negedge clk); ctrl_arm = 1;   @(negedge clk); ctrl_arm = 0;   endtask
  task automatic pulse_abort(); @(negedge clk); ctrl_abort = 1; @(negedge clk); ctrl_abort = 0; endtask
  task automatic pulse_sw();    @(negedge clk); sw_trig = 1;    @(negedge clk); sw_trig = 0;    endtask

  task automatic ext_async();
    @(negedge clk);
    #($urandom_range(1, 3));
    ext_trig = 1'b1;
    repeat (3) @(negedge clk);
    #1 ext_trig = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int i = 0;
    @(negedge clk);
    while (sts_busy && i < bound) begin @(negedge clk); i++; end
    chk(name, sts_busy, 1'b0);
  endtask

  task automatic wait_bfm_idle();
    int i = 0;
    while ((bfm_st != 0 || !rx_sr_pc) && i < 200) begin @(negedge clk); i++; end
    chk("bfm_idle", rx_sr_pc, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0, i0, k;
    rst_n = 0; ctrl_arm = 0; ctrl_abort = 0; sw_trig = 0; ext_trig = 0;
    set_cfg(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", sts_busy, 0);
    chk("rst_start", rx_start, 0);
    chk("rst_irq", irq, 0);
    chk("rst_frame_cnt", sts_frame_cnt, 0);
    chk("rst_dsize", rx_dsize, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // 1: three back-to-back packets
    set_cfg(3, 0, 0, 16, 1, 0); bfm_mode = 0; bfm_drop = 2; bfm_busy = 20;
    s0 = n_starts; i0 = n_irq;
    pulse_arm();
    repeat (2) @(negedge clk);
    pulse_sw();
    wait_idle(500, "t1_idle");
    chk("t1_starts", n_starts - s0, 3);
    chk("t1_frame_cnt", sts_frame_cnt, 3);
    chk("t1_done", sts_done, 1);
    chk("t1_irqs", n_irq - i0, 1);
    chk("t1_dsize", rx_dsize, 16);

    // 2: inter-frame gap of 10
    wait_bfm_idle();
    set_cfg(2, 10, 0, 8, 0, 0); bfm_drop = 1; bfm_busy = 5;
    s0 = n_starts;
    pulse_arm(); pulse_sw();
    wait_idle(500, "t2_idle");
    chk("t2_starts", n_starts - s0, 2);
    chk("t2_gap", start_gap, 10);
    chk("t2_done", sts_done, 1);

    // 3: watchdog with unresponsive receiver
    wait_bfm_idle();
    set_cfg(1, 0, 50, 4, 0, 0); bfm_mode = 1;
    i0 = n_irq;
    pulse_arm(); pulse_sw();
    wait_idle(200, "t3_idle");
    chk("t3_wd_latency", irq_cyc - start_rise, 50);
    chk("t3_timeout", sts_timeout, 1);
    chk("t3_rx_start", rx_start, 0);
    chk("t3_done", sts_done, 0);
    chk("t3_irqs", n_irq - i0, 1);
    bfm_mode = 0;

    // 4: continuous mode aborted after 5 packets
    wait_bfm_idle();
    set_cfg(0, 0, 0, 4, 0, 0); bfm_drop = 1; bfm_busy = 3;
    i0 = n_irq;
    pulse_arm(); pulse_sw();
    k = 0;
    while (sts_frame_cnt != 5 && k < 1000) begin @(negedge clk); k++; end
    chk("t4_reach5", sts_frame_cnt, 5);
    ctrl_abort = 1; @(negedge clk); ctrl_abort = 0;
    chk("t4_busy", sts_busy, 0);
    chk("t4_frame_cnt", sts_frame_cnt, 5);
    chk("t4_done", sts_done, 0);
    chk("t4_irqs", n_irq - i0, 0);

    // 5: external trigger
    wait_bfm_idle();
    set_cfg(1, 0, 0, 4, 0, 1);
    pulse_arm();
    repeat (3) @(negedge clk);
    @(negedge clk);
    #($urandom_range(1, 3));
    ext_trig = 1'b1;
    k = 0;
    while (!rx_start && k < 20) begin @(posedge clk); #1; k++; end
    @(negedge clk); ext_trig = 1'b0;
`ifdef ACQ_SEQ_EXT_TRIG_EN
    chk("t5_ext_latency", k, SYNC + 2);
    wait_idle(200, "t5_idle");
    chk("t5_done", sts_done, 1);
`else
    chk("t5_no_start", rx_start, 0);
    chk("t5_waiting", sts_busy, 1);
    pulse_abort();
`endif

    // 6: async reset while a packet is in flight, then arm+abort together
    wait_bfm_idle();
    set_cfg(1, 0, 0, 9, 1, 0); bfm_drop = 1; bfm_busy = 30;
    pulse_arm(); pulse_sw();
    k = 0;
    while (!(sts_busy && !rx_start && !rx_sr_pc) && k < 100) begin @(negedge clk); k++; end
    chk("t6_in_run", rx_sr_pc, 0);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_start", rx_start, 0);
    chk("t6_rst_busy", sts_busy, 0);
    chk("t6_rst_dsize", rx_dsize, 0);
    chk("t6_rst_test", rx_test, 0);
    chk("t6_rst_cnt", sts_frame_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    ctrl_arm = 1; ctrl_abort = 1;
    @(negedge clk);
    ctrl_arm = 0; ctrl_abort = 0;
    chk("t6_arm_abort_idle", sts_busy, 0);

    // random sequences
    for (int it = 0; it < 40; it++) begin
      logic src;
      if ($urandom_range(0, 1) == 1) wait_bfm_idle();
      src = ($urandom_range(0, 3) == 0);
      set_cfg($urandom_range(0, 4), $urandom_range(0, 6),
              ($urandom_range(0, 1) == 1) ? $urandom_range(15, 80) : 0,
              $urandom, $urandom_range(0, 1) == 1, src);
      bfm_mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
      bfm_drop = $urandom_range(0, 4);
      bfm_busy = $urandom_range(1, 25);
      pulse_arm();
      set_cfg($urandom, $urandom, $urandom, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (src) ext_async(); else pulse_sw();
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        sw_trig    = ($urandom_range(0, 39) == 0);
        ctrl_arm   = ($urandom_range(0, 99) == 0);
        ctrl_abort = ($urandom_range(0, 299) == 0);
        if (!sts_busy && c > 5) break;
      end
      sw_trig = 0; ctrl_arm = 0; ctrl_abort = 0;
      if (sts_busy) pulse_abort();
      bfm_mode = 0;
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
